id_operand_stage: RTL and testbench

- Decode / operand-fetch stage of the RV32I pipeline.
- Takes a fetched instruction from IF over a valid/ready handshake and drives the register-file read addresses.
- Merges register-file read data with bypass data from EX and WB, generates the immediate and the control word, and holds the result in the ID/EX pipeline register for the execute stage.
- Detects load-use hazards and stalls upstream.

---
 rtl/id_operand_stage_pkg.sv | 82 ++++++++
 rtl/id_operand_stage_imm_gen.sv | 32 +++
 rtl/id_operand_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_id_operand_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_operand_stage_pkg.sv
// Shared decode types for the RV32I ID stage: opcodes, immediate formats, ALU ops and the control word.
package pkg_config;

  localparam int unsigned NUM_REGISTER_DEF = 32;
  localparam int unsigned REG_ADDR_W       = $clog2(NUM_REGISTER_DEF);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_LUI,
    ALU_AUIPC,
    ALU_LINK
  } alu_op_e;

  typedef struct packed {
    alu_op_e   alu_op;
    logic      src_b_imm;
    logic      mem_rd;
    logic      mem_wr;
    logic      reg_we;
    logic      branch;
    logic      jump;
    imm_type_e imm_type;
    logic [2:0] funct3;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    alu_op:    ALU_ADD,
    src_b_imm: 1'b0,
    mem_rd:    1'b0,
    mem_wr:    1'b0,
    reg_we:    1'b0,
    branch:    1'b0,
    jump:      1'b0,
    imm_type:  IMM_I,
    funct3:    3'b000
  };

  // alt is instr[30]; SUB only exists in the register-register form.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt,
                                              input logic reg_form);
    case (f3)
      3'b000:  return (alt && reg_form) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_operand_stage_imm_gen.sv
// Combinational RV32I immediate generator; result sign-extended to DATA_WIDTH.
module imm_gen
  import pkg_config::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [31:0]           i_instr,
  input  imm_type_e             i_imm_type,
  output logic [DATA_WIDTH-1:0] o_imm
);

  logic [31:0] w_imm32;
  logic        w_unused_opcode;

  always_comb begin
    w_imm32 = '0;
    case (i_imm_type)
      IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                          i_instr[11:8], 1'b0};
      IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                          i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign o_imm           = DATA_WIDTH'($signed(w_imm32));
  assign w_unused_opcode = ^i_instr[6:0];

endmodule

// File: rtl/id_operand_stage.sv
// RV32I decode / operand-fetch stage with ID/EX register, bypass and load-use stall.
// ID_FORWARD_EN: enables EX-result bypass; without it any EX write match on a used source stalls.
module id_operand_stage
  import pkg_config::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_REGISTER = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [DATA_WIDTH-1:0]           in_instr_i,
  input  logic [DATA_WIDTH-1:0]           in_pc_i,
  output logic [$clog2(NUM_REGISTER)-1:0] rs1_addr_o,
  output logic [$clog2(NUM_REGISTER)-1:0] rs2_addr_o,
  input  logic [DATA_WIDTH-1:0]           rs1_i,
  input  logic [DATA_WIDTH-1:0]           rs2_i,
  input  logic                            ex_we_i,
  input  logic                            ex_is_load_i,
  input  logic [$clog2(NUM_REGISTER)-1:0] ex_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]           ex_result_i,
  input  logic                            wb_we_i,
  input  logic [$clog2(NUM_REGISTER)-1:0] wb_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]           wb_data_i,
  input  logic                            flush_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [DATA_WIDTH-1:0]           out_pc_o,
  output logic [DATA_WIDTH-1:0]           out_rs1_data_o,
  output logic [DATA_WIDTH-1:0]           out_rs2_data_o,
  output logic [DATA_WIDTH-1:0]           out_imm_o,
  output logic [$clog2(NUM_REGISTER)-1:0] out_rd_addr_o,
  output ctrl_t                           out_ctrl_o,
  output logic                            out_illegal_o
);

  localparam int unsigned AW = $clog2(NUM_REGISTER);

  logic [AW-1:0]         w_rs1_addr;
  logic [AW-1:0]         w_rs2_addr;
  logic [AW-1:0]         w_rd_addr;
  ctrl_t                 w_ctrl;
  logic                  w_rs1_used;
  logic                  w_rs2_used;
  logic                  w_illegal;
  logic [DATA_WIDTH-1:0] w_imm;
  logic [DATA_WIDTH-1:0] w_rs1_data;
  logic [DATA_WIDTH-1:0] w_rs2_data;
  logic                  w_ex_hit1;
  logic                  w_ex_hit2;
  logic                  w_hazard;
  logic                  w_accept;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_rs1_data;
  logic [DATA_WIDTH-1:0] r_rs2_data;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [AW-1:0]         r_rd_addr;
  ctrl_t                 r_ctrl;
  logic                  r_illegal;

  assign w_rs1_addr = AW'(in_instr_i[19:15]);
  assign w_rs2_addr = AW'(in_instr_i[24:20]);
  assign w_rd_addr  = AW'(in_instr_i[11:7]);
  assign rs1_addr_o = w_rs1_addr;
  assign rs2_addr_o = w_rs2_addr;

  always_comb begin
    w_ctrl        = CTRL_NOP;
    w_ctrl.funct3 = in_instr_i[14:12];
    w_rs1_used    = 1'b0;
    w_rs2_used    = 1'b0;
    w_illegal     = 1'b0;
    case (in_instr_i[6:0])
      OPC_LUI: begin
        w_ctrl.alu_op    = ALU_LUI;
        w_ctrl.src_b_imm = 1'b1;
        w_ctrl.reg_we    = 1'b1;
        w_ctrl.imm_type  = IMM_U;
      end
      OPC_AUIPC: begin
        w_ctrl.alu_op    = ALU_AUIPC;
        w_ctrl.src_b_imm = 1'b1;
        w_ctrl.reg_we    = 1'b1;
        w_ctrl.imm_type  = IMM_U;
      end
      OPC_JAL: begin
        w_ctrl.alu_op   = ALU_LINK;
        w_ctrl.jump     = 1'b1;
        w_ctrl.reg_we   = 1'b1;
        w_ctrl.imm_type = IMM_J;
      end
      OPC_JALR: begin
        w_ctrl.alu_op   = ALU_LINK;
        w_ctrl.jump     = 1'b1;
        w_ctrl.reg_we   = 1'b1;
        w_ctrl.imm_type = IMM_I;
        w_rs1_used      = 1'b1;
      end
      OPC_BRANCH: begin
        w_ctrl.alu_op   = ALU_SUB;
        w_ctrl.branch   = 1'b1;
        w_ctrl.imm_type = IMM_B;
        w_rs1_used      = 1'b1;
        w_rs2_used      = 1'b1;
      end
      OPC_LOAD: begin
        w_ctrl.alu_op    = ALU_ADD;
        w_ctrl.src_b_imm = 1'b1;
        w_ctrl.mem_rd    = 1'b1;
        w_ctrl.reg_we    = 1'b1;
        w_ctrl.imm_type  = IMM_I;
        w_rs1_used       = 1'b1;
      end
      OPC_STORE: begin
        w_ctrl.alu_op    = ALU_ADD;
        w_ctrl.src_b_imm = 1'b1;
        w_ctrl.mem_wr    = 1'b1;
        w_ctrl.imm_type  = IMM_S;
        w_rs1_used       = 1'b1;
        w_rs2_used       = 1'b1;
      end
      OPC_OP_IMM: begin
        w_ctrl.alu_op    = alu_from_funct3(in_instr_i[14:12], in_instr_i[30], 1'b0);
        w_ctrl.src_b_imm = 1'b1;
        w_ctrl.reg_we    = 1'b1;
        w_ctrl.imm_type  = IMM_I;
        w_rs1_used       = 1'b1;
      end
      OPC_OP: begin
        w_ctrl.alu_op = alu_from_funct3(in_instr_i[14:12], in_instr_i[30], 1'b1);
        w_ctrl.reg_we = 1'b1;
        w_rs1_used    = 1'b1;
        w_rs2_used    = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  imm_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_imm_gen (
    .i_instr   (in_instr_i[31:0]),
    .i_imm_type(w_ctrl.imm_type),
    .o_imm     (w_imm)
  );

  assign w_ex_hit1 = ex_we_i && (ex_rd_addr_i != '0) && (ex_rd_addr_i == w_rs1_addr) && w_rs1_used;
  assign w_ex_hit2 = ex_we_i && (ex_rd_addr_i != '0) && (ex_rd_addr_i == w_rs2_addr) && w_rs2_used;

`ifdef ID_FORWARD_EN
  assign w_hazard = ex_is_load_i && (w_ex_hit1 || w_ex_hit2);

  always_comb begin
    w_rs1_data = rs1_i;
    if (w_rs1_addr == '0)
      w_rs1_data = '0;
    else if (ex_we_i && !ex_is_load_i && (ex_rd_addr_i == w_rs1_addr))
      w_rs1_data = ex_result_i;
    else if (wb_we_i && (wb_rd_addr_i == w_rs1_addr))
      w_rs1_data = wb_data_i;
  end

  always_comb begin
    w_rs2_data = rs2_i;
    if (w_rs2_addr == '0)
      w_rs2_data = '0;
    else if (ex_we_i && !ex_is_load_i && (ex_rd_addr_i == w_rs2_addr))
      w_rs2_data = ex_result_i;
    else if (wb_we_i && (wb_rd_addr_i == w_rs2_addr))
      w_rs2_data = wb_data_i;
  end
`else
  logic w_unused_ex;

  assign w_hazard    = w_ex_hit1 || w_ex_hit2;
  assign w_unused_ex = ^{ex_result_i, ex_is_load_i};

  // WB bypass stays: the register file does not write through on the same edge.
  always_comb begin
    w_rs1_data = rs1_i;
    if (w_rs1_addr == '0)
      w_rs1_data = '0;
    else if (wb_we_i && (wb_rd_addr_i == w_rs1_addr))
      w_rs1_data = wb_data_i;
  end

  always_comb begin
    w_rs2_data = rs2_i;
    if (w_rs2_addr == '0)
      w_rs2_data = '0;
    else if (wb_we_i && (wb_rd_addr_i == w_rs2_addr))
      w_rs2_data = wb_data_i;
  end
`endif

  assign in_ready_o = !w_hazard && !flush_i && (!r_valid || out_ready_i);
  assign w_accept   = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd_addr  <= '0;
      r_ctrl     <= CTRL_NOP;
      r_illegal  <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= in_pc_i;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_rd_addr  <= w_rd_addr;
      r_ctrl     <= w_ctrl;
      r_illegal  <= w_illegal;
    end else if (out_ready_i) begin
      // Drain, or bubble when a hazard blocks capture.
      r_valid <= 1'b0;
    end
  end

  assign out_valid_o    = r_valid;
  assign out_pc_o       = r_pc;
  assign out_rs1_data_o = r_rs1_data;
  assign out_rs2_data_o = r_rs2_data;
  assign out_imm_o      = r_imm;
  assign out_rd_addr_o  = r_rd_addr;
  assign out_ctrl_o     = r_ctrl;
  assign out_illegal_o  = r_illegal;

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_id_operand_stage;
  import pkg_config::*;

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMMA = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_instr_i = '0;
  logic [31:0] in_pc_i = '0;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_i = '0, rs2_i = '0;
  logic        ex_we_i = 1'b0, ex_is_load_i = 1'b0;
  logic [4:0]  ex_rd_addr_i = '0;
  logic [31:0] ex_result_i = '0;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_rd_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_pc_o, out_rs1_data_o, out_rs2_data_o, out_imm_o;
  logic [4:0]  out_rd_addr_o;
  ctrl_t       out_ctrl_o;
  logic        out_illegal_o;

  always #5 clk = ~clk;

  id_operand_stage #(
    .DATA_WIDTH  (32),
    .NUM_REGISTER(32)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i),
    .ex_we_i(ex_we_i), .ex_is_load_i(ex_is_load_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_result_i(ex_result_i),
    .wb_we_i(wb_we_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_rs1_data_o(out_rs1_data_o),
    .out_rs2_data_o(out_rs2_data_o), .out_imm_o(out_imm_o),
    .out_rd_addr_o(out_rd_addr_o), .out_ctrl_o(out_ctrl_o),
    .out_illegal_o(out_illegal_o)
  );

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [6:0]  flags;
    logic        chk_imm;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic        exp_valid = 1'b0;
  logic [31:0] pc_ctr = 32'h1000;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic known_op(logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMMA, OP_REG};
  endfunction

  function automatic logic uses_rs1(logic [6:0] op);
    return known_op(op) && !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic logic uses_rs2(logic [6:0] op);
    return op inside {OP_BR, OP_ST, OP_REG};
  endfunction

  // {reg_we, mem_rd, mem_wr, branch, jump, src_b_imm, illegal}
  function automatic logic [6:0] ref_flags(logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC:  return 7'b1000010;
      OP_JAL, OP_JALR:   return 7'b1000100;
      OP_BR:             return 7'b0001000;
      OP_LD:             return 7'b1100010;
      OP_ST:             return 7'b0010010;
      OP_IMMA:           return 7'b1000010;
      OP_REG:            return 7'b1000000;
      default:           return 7'b0000001;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(logic [31:0] ins);
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    case (ins[6:0])
      OP_LUI, OP_AUIPC: return ins & 32'hFFFF_F000;
      OP_ST: begin
        i12 = {ins[31:25], ins[11:7]};
        return 32'(i12);
      end
      OP_BR: begin
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        return 32'(b13);
      end
      OP_JAL: begin
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        return 32'(j21);
      end
      default: begin
        i12 = ins[31:20];
        return 32'(i12);
      end
    endcase
  endfunction

  function automatic logic [31:0] ref_operand(logic [4:0] a, logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
`ifdef ID_FORWARD_EN
    if (ex_we_i && !ex_is_load_i && ex_rd_addr_i == a) return ex_result_i;
`endif
    if (wb_we_i && wb_rd_addr_i == a) return wb_data_i;
    return rf;
  endfunction

  task automatic evaluate();
    logic [6:0] op;
    logic       h1, h2, haz, rdy;
    exp_t       e;
    @(negedge clk);
    op  = in_instr_i[6:0];
    h1  = uses_rs1(op) && ex_we_i && ex_rd_addr_i == in_instr_i[19:15] && in_instr_i[19:15] != 0;
    h2  = uses_rs2(op) && ex_we_i && ex_rd_addr_i == in_instr_i[24:20] && in_instr_i[24:20] != 0;
`ifdef ID_FORWARD_EN
    haz = ex_is_load_i && (h1 || h2);
`else
    haz = h1 || h2;
`endif
    rdy = !haz && !flush_i && (!exp_valid || out_ready_i);
    check("in_ready", 32'(in_ready_o), 32'(rdy));
    check("out_valid", 32'(out_valid_o), 32'(exp_valid));
    if (in_valid_i && rdy) begin
      e.pc      = in_pc_i;
      e.rs1     = ref_operand(in_instr_i[19:15], rs1_i);
      e.rs2     = ref_operand(in_instr_i[24:20], rs2_i);
      e.imm     = ref_imm(in_instr_i);
      e.rd      = in_instr_i[11:7];
      e.flags   = ref_flags(op);
      e.chk_imm = known_op(op);
      q.push_back(e);
    end
    if (flush_i) exp_valid = 1'b0;
    else if (in_valid_i && rdy) exp_valid = 1'b1;
    else if (out_ready_i) exp_valid = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1, r2,
                       input logic ew, el, input logic [4:0] er, input logic [31:0] eres,
                       input logic ww, input logic [4:0] wr, input logic [31:0] wd,
                       input logic fl, ordy);
    @(posedge clk);
    #1;
    in_valid_i = v;   in_instr_i = ins;  in_pc_i = pc_ctr;  pc_ctr += 4;
    rs1_i = r1;       rs2_i = r2;
    ex_we_i = ew;     ex_is_load_i = el; ex_rd_addr_i = er;  ex_result_i = eres;
    wb_we_i = ww;     wb_rd_addr_i = wr; wb_data_i = wd;
    flush_i = fl;     out_ready_i = ordy;
    evaluate();
  endtask

  task automatic idle();
    drive(1'b0, 32'h0000_0013, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  // Monitor: compares the held op against the scoreboard front every cycle it is valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && out_valid_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got valid=1 expected valid=0");
        end else begin
          e = q[0];
          check("out_pc", out_pc_o, e.pc);
          check("out_rs1_data", out_rs1_data_o, e.rs1);
          check("out_rs2_data", out_rs2_data_o, e.rs2);
          check("out_rd_addr", 32'(out_rd_addr_o), 32'(e.rd));
          check("ctrl_flags", 32'({out_ctrl_o.reg_we, out_ctrl_o.mem_rd, out_ctrl_o.mem_wr,
                                   out_ctrl_o.branch, out_ctrl_o.jump, out_ctrl_o.src_b_imm,
                                   out_illegal_o}), 32'(e.flags));
          if (e.chk_imm) check("out_imm", out_imm_o, e.imm);
          if (flush_i || out_ready_i) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  op;

    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid_o), 32'd0);
    check("reset_ctrl", 32'(out_ctrl_o), 32'(CTRL_NOP));
    check("reset_imm", out_imm_o, 32'd0);
    rst_i = 1'b0;

    // addi x5,x0,-1
    drive(1'b1, 32'hFFF0_0293, 32'h55, 32'h66, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle();

    // Reset arriving while a captured op is held.
    drive(1'b1, 32'hFFF0_0293, 32'h55, 32'h66, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_reset_valid", 32'(out_valid_o), 32'(exp_valid));
    rst_i = 1'b1;
    #1;
    check("mid_reset_valid", 32'(out_valid_o), 32'd0);
    check("mid_reset_ctrl", 32'(out_ctrl_o), 32'(CTRL_NOP));
    q.delete();
    exp_valid = 1'b0;
    in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    check("held_reset_valid", 32'(out_valid_o), 32'd0);
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    evaluate();
    idle();

    // add x3,x1,x2 with EX match on x1 and WB match on x2
    drive(1'b1, 32'h0020_81B3, 32'd7, 32'd9, 1'b1, 1'b0, 5'd1, 32'h10, 1'b1, 5'd2, 32'h20, 1'b0, 1'b1);
    drive(1'b1, 32'h0020_81B3, 32'd7, 32'd9, 1'b1, 1'b0, 5'd1, 32'h10, 1'b1, 5'd2, 32'h20, 1'b0, 1'b1);
    drive(1'b1, 32'h0020_81B3, 32'd7, 32'd9, 1'b0, 1'b0, 5'd1, 32'h10, 1'b1, 5'd2, 32'h20, 1'b0, 1'b1);
    idle();

    // Load-use on x1, then load retires, then EX write clears.
    drive(1'b1, 32'h0020_81B3, 32'd7, 32'd9, 1'b1, 1'b1, 5'd1, 32'h30, 1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b1, 32'h0020_81B3, 32'd7, 32'd9, 1'b1, 1'b0, 5'd1, 32'h30, 1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b1, 32'h0020_81B3, 32'd7, 32'd9, 1'b0, 1'b0, 5'd1, 32'h30, 1'b0, '0, '0, 1'b0, 1'b1);
    idle();

    // Backpressure for 3 cycles, then 4 ops streamed back-to-back.
    drive(1'b1, 32'h0010_0093, 32'd1, 32'd2, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      drive(1'b1, 32'h0020_0113, 32'd1, 32'd2, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int k = 2; k < 6; k++) begin
      ins = {12'(k), 5'd0, 3'd0, 5'(k), 7'h13};
      drive(1'b1, ins, 32'd1, 32'd2, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    end
    idle();

    // Flush with a held op and a pending input, then an illegal opcode.
    drive(1'b1, 32'h0010_0093, 32'd1, 32'd2, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b1, 32'h0020_0113, 32'd1, 32'd2, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b1, 32'h0000_007F, 32'd1, 32'd2, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle();

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: op = OP_LUI;   1: op = OP_AUIPC; 2: op = OP_JAL;  3: op = OP_JALR;
        4: op = OP_BR;    5: op = OP_LD;    6: op = OP_ST;   7: op = OP_IMMA;
        8: op = OP_REG;   default: op = 7'h7F;
      endcase
      ins        = $urandom;
      ins[6:0]   = op;
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      drive($urandom_range(0, 9) < 8, ins, $urandom, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, 5'($urandom_range(0, 3)),
            $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 99) < 8, $urandom_range(0, 3) != 0);
    end
    idle();
    idle();
    check("drain_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
